// File: rtl/bsg_comm_link_pkg.sv
// Shared types and helpers for the source-synchronous comm link calibration logic.
package bsg_comm_link_pkg;

  typedef enum logic [2:0] {
    e_calib_idle    = 3'd0,
    e_calib_prepare = 3'd1,
    e_calib_run     = 3'd2,
    e_calib_done    = 3'd3,
    e_calib_error   = 3'd4
  } bsg_calib_ctrl_state_e;

  // Masks narrower than 64 bits are zero-extended by the caller.
  function automatic int unsigned bsg_calib_popcount(input logic [63:0] v);
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < 64; i++) sum += 32'(v[i]);
    return sum;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear takes priority over count.
module bsg_counter_clear_up #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_r_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) count_r_o <= '0;
    else if (up_i)          count_r_o <= count_r_o + 1'b1;
  end

endmodule

// File: rtl/bsg_source_sync_channel_control_master_ft.sv
// Fault-tolerant calibration sequencer: runs each test after a timed prepare
// phase, drops channels that time out and restarts on the survivors.
module bsg_source_sync_channel_control_master_ft
  import bsg_comm_link_pkg::*;
#(
  parameter int link_channels_p     = 4,
  parameter int tests_p             = 2,
  parameter int prepare_cycles_p    = 4,
  parameter int timeout_cycles_p    = 16,
  parameter int min_good_channels_p = 1,
  localparam int idx_w_lp = (tests_p > 0) ? $clog2(tests_p + 1) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   start_i,
  input  logic [tests_p:0][link_channels_p-1:0]  test_scoreboard_i,
  output logic [idx_w_lp-1:0]                    test_index_r_o,
  output logic                                   prepare_o,
  output logic [link_channels_p-1:0]             channel_active_o,
  output logic                                   done_o,
  output logic                                   error_o
);

  localparam int ctr_max_lp = (prepare_cycles_p > timeout_cycles_p) ? prepare_cycles_p
                                                                     : timeout_cycles_p;
  localparam int ctr_w_lp   = $clog2(ctr_max_lp + 1);

  bsg_calib_ctrl_state_e        state_r, state_n;
  logic [idx_w_lp-1:0]          idx_r, idx_n;
  logic [link_channels_p-1:0]   mask_r, mask_n;
  logic [link_channels_p-1:0]   cur_sb, new_mask;
  logic [ctr_w_lp-1:0]          ctr_r;
  logic                         pass, ctr_clear, ctr_up;
  logic                         prep_last, run_last;

  assign cur_sb    = test_scoreboard_i[idx_r];
  // Inactive channels are forced to pass so stale scoreboard bits cannot stall a test.
  assign pass      = &(cur_sb | ~mask_r);
  assign new_mask  = mask_r & cur_sb;
  assign prep_last = (ctr_r == ctr_w_lp'(prepare_cycles_p - 1));
  assign run_last  = (ctr_r == ctr_w_lp'(timeout_cycles_p - 1));

  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    mask_n  = mask_r;
    unique case (state_r)
      e_calib_idle: begin
        if (start_i) begin
          state_n = e_calib_prepare;
          idx_n   = '0;
        end
      end
      e_calib_prepare: begin
        if (prep_last) state_n = e_calib_run;
      end
      e_calib_run: begin
        if (pass) begin
          if (idx_r == idx_w_lp'(tests_p)) begin
            state_n = e_calib_done;
          end else begin
            state_n = e_calib_prepare;
            idx_n   = idx_r + 1'b1;
          end
        end else if (run_last) begin
          mask_n = new_mask;
          if (int'(bsg_calib_popcount(64'(new_mask))) >= min_good_channels_p) begin
            state_n = e_calib_prepare;
            idx_n   = '0;
          end else begin
            state_n = e_calib_error;
          end
        end
      end
      e_calib_done:  state_n = e_calib_done;
      e_calib_error: state_n = e_calib_error;
      default:       state_n = e_calib_idle;
    endcase
  end

  // Clearing on every state change keeps the phase counter from ever wrapping.
  assign ctr_clear = (state_n != state_r) || (state_r == e_calib_idle);
  assign ctr_up    = (state_r == e_calib_prepare) || (state_r == e_calib_run);

  bsg_counter_clear_up #(.width_p(ctr_w_lp)) phase_ctr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (ctr_clear),
    .up_i      (ctr_up),
    .count_r_o (ctr_r)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_calib_idle;
      idx_r   <= '0;
      mask_r  <= '1;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      mask_r  <= mask_n;
    end
  end

  assign test_index_r_o   = idx_r;
  assign channel_active_o = mask_r;
  assign prepare_o        = (state_r == e_calib_prepare);
  assign done_o           = (state_r == e_calib_done);
  assign error_o          = (state_r == e_calib_error);

endmodule

// File: tb/tb_bsg_source_sync_channel_control_master_ft.sv
// Directed bench for the fault-tolerant calibration sequencer (4 channels, 3 tests).
module tb_bsg_source_sync_channel_control_master_ft;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0][3:0] sb;
  logic [1:0]      idx;
  logic            prep;
  logic [3:0]      mask;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_source_sync_channel_control_master_ft #(
    .link_channels_p     (4),
    .tests_p             (2),
    .prepare_cycles_p    (4),
    .timeout_cycles_p    (16),
    .min_good_channels_p (2)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .start_i           (start),
    .test_scoreboard_i (sb),
    .test_index_r_o    (idx),
    .prepare_o         (prep),
    .channel_active_o  (mask),
    .done_o            (done),
    .error_o           (err)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [11:0] sbv;
    logic [1:0]  e_idx;
    logic        e_prep;
    logic [3:0]  e_mask;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl [18];

  task automatic step(input logic r, input logic s, input logic [11:0] b);
    reset = r;
    start = s;
    sb    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Steps until the predicate-like condition below holds; returns steps taken or -1.
  task automatic wait_run_of(input logic [1:0] want_idx, input logic [11:0] b, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b0, b);
      if (idx == want_idx && !prep && !done && !err) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_prep(input logic [11:0] b, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b0, b);
      if (prep || err || done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_end(input logic [11:0] b, output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      step(1'b0, 1'b0, b);
      if (done || err) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    sb    = '0;

    // Scenario 1 plus ignored start pulses: rows are one clock edge each.
    tbl[0]  = '{1'b1, 1'b0, 12'hFFF, 2'd0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 12'hFFF, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 12'hFFF, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 12'hFFF, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 12'hFFF, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 12'hFFF, 2'd0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 12'hFFF, 2'd1, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 12'hFFF, 2'd1, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 12'hFFF, 2'd1, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 12'hFFF, 2'd1, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 12'hFFF, 2'd1, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 12'hFFF, 2'd2, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 12'hFFF, 2'd2, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 12'hFFF, 2'd2, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 12'hFFF, 2'd2, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 12'hFFF, 2'd2, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 12'hFFF, 2'd2, 1'b0, 4'hF, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 12'hFFF, 2'd2, 1'b0, 4'hF, 1'b1, 1'b0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].sbv);
      chk($sformatf("tbl%0d.idx", i),  32'(idx),  32'(tbl[i].e_idx));
      chk($sformatf("tbl%0d.prep", i), 32'(prep), 32'(tbl[i].e_prep));
      chk($sformatf("tbl%0d.mask", i), 32'(mask), 32'(tbl[i].e_mask));
      chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.err", i),  32'(err),  32'(tbl[i].e_err));
    end

    // Scenario 2: channel 3 never passes test 1, then stale bit 3 in test 0 is ignored.
    step(1'b1, 1'b0, 12'hFFF);
    step(1'b0, 1'b1, 12'hF7F);
    wait_run_of(2'd1, 12'hF7F, n);
    chk("s2.reach_run1", 32'(n > 0), 32'd1);
    wait_prep(12'hF7F, n);
    chk("s2.timeout_cycles", 32'(n), 32'd16);
    chk("s2.mask", 32'(mask), 32'h7);
    chk("s2.idx", 32'(idx), 32'd0);
    chk("s2.prep", 32'(prep), 32'd1);
    wait_end(12'hF77, n);
    chk("s2.done", 32'(done), 32'd1);
    chk("s2.err", 32'(err), 32'd0);
    chk("s2.final_mask", 32'(mask), 32'h7);

    // Scenario 3: three channels fail test 0 -> too few survivors.
    step(1'b1, 1'b0, 12'hFFF);
    chk("s3.reset_err", 32'(err), 32'd0);
    step(1'b0, 1'b1, 12'hFF1);
    wait_end(12'hFF1, n);
    chk("s3.steps_to_error", 32'(n), 32'd20);
    chk("s3.err", 32'(err), 32'd1);
    chk("s3.done", 32'(done), 32'd0);
    chk("s3.mask", 32'(mask), 32'h1);
    step(1'b0, 1'b1, 12'hFFF);
    step(1'b0, 1'b0, 12'hFFF);
    chk("s3.err_sticky", 32'(err), 32'd1);
    chk("s3.prep_held", 32'(prep), 32'd0);

    // Scenario 4: pass arrives on the very cycle the timeout would fire.
    step(1'b1, 1'b0, 12'hFFF);
    step(1'b0, 1'b1, 12'hFF7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'hFF7);
    chk("s4.in_run", 32'(prep), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 12'hFF7);
    chk("s4.no_early_timeout", 32'({prep, idx, mask}), 32'({1'b0, 2'd0, 4'hF}));
    step(1'b0, 1'b0, 12'hFFF);
    chk("s4.idx", 32'(idx), 32'd1);
    chk("s4.prep", 32'(prep), 32'd1);
    chk("s4.mask", 32'(mask), 32'hF);

    // Scenario 5: drop a channel, reach RUN of test 2, then reset mid-sequence.
    step(1'b1, 1'b0, 12'hFFF);
    step(1'b0, 1'b1, 12'hFBF);
    wait_run_of(2'd1, 12'hFBF, n);
    wait_prep(12'hFBF, n);
    chk("s5.mask_dropped", 32'(mask), 32'hB);
    wait_run_of(2'd2, 12'hBBB, n);
    chk("s5.reach_run2", 32'(n > 0), 32'd1);
    chk("s5.in_run2", 32'({idx, prep, done}), 32'({2'd2, 1'b0, 1'b0}));
    step(1'b1, 1'b0, 12'hFFF);
    chk("s5.rst_idx", 32'(idx), 32'd0);
    chk("s5.rst_prep", 32'(prep), 32'd0);
    chk("s5.rst_mask", 32'(mask), 32'hF);
    chk("s5.rst_flags", 32'({done, err}), 32'd0);
    step(1'b0, 1'b0, 12'hFFF);
    chk("s5.idle_wait", 32'(prep), 32'd0);
    step(1'b0, 1'b1, 12'hFFF);
    wait_end(12'hFFF, n);
    chk("s5.steps_to_done", 32'(n + 1), 32'd16);
    chk("s5.done", 32'(done), 32'd1);
    chk("s5.mask_full", 32'(mask), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
